// File: rtl/mem_access_if.sv
// Load/store request and response channel between the MEM-stage pipeline
// (master) and the memory access controller (slave).
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store initiator: byte-addressed requests in, word-indexed
// memory accesses out, with read-modify-write for sub-word stores.
module mem_access_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_access_if.slave bus,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_write_data_o,
  output logic        mem_memwrite_o,
  output logic        mem_memread_o,
  input  logic [31:0] mem_read_data_i
);

  localparam int unsigned AW = DEPTH_LOG2 + 2;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP} state_e;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  state_e      state_q, state_d;
  logic        accept;
  logic        req_err;

  size_e       size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        signed_q;

  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        memread_q, memread_d;
  logic        memwrite_q, memwrite_d;

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;

  assign accept  = (state_q == S_IDLE) && bus.req_valid;
  assign req_err = (bus.req_size == SZ_ILL)
                || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
                || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00))
                || (bus.req_addr[31:AW] != '0);

  // Lane extraction and extension of the word returned by a load read.
  assign lane_byte = 8'(mem_read_data_i >> {lane_q, 3'b000});
  assign lane_half = 16'(mem_read_data_i >> {lane_q[1], 4'b0000});

  always_comb begin
    unique case (size_q)
      SZ_BYTE: load_val = {{24{signed_q & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_val = {{16{signed_q & lane_half[15]}}, lane_half};
      default: load_val = mem_read_data_i;
    endcase
  end

  // Sub-word store merge: only the addressed lane is replaced.
  assign lane_mask = (size_q == SZ_BYTE) ? (32'h0000_00FF << {lane_q, 3'b000})
                                         : (32'h0000_FFFF << {lane_q[1], 4'b0000});
  assign lane_data = (size_q == SZ_BYTE) ? ({24'h0, wdata_q[7:0]} << {lane_q, 3'b000})
                                         : ({16'h0, wdata_q} << {lane_q[1], 4'b0000});
  assign merged    = (mem_read_data_i & ~lane_mask) | lane_data;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (req_err)                    state_d = S_RESP;
          else if (!bus.req_write)        state_d = S_RD;
          else if (bus.req_size == SZ_WORD) state_d = S_WR;
          else                            state_d = S_RMW_RD;
        end
      end
      S_RD:     state_d = S_RESP;
      S_RMW_RD: state_d = S_WR;
      S_WR:     state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are computed for the next state and registered alongside it.
  always_comb begin
    ready_d     = (state_d == S_IDLE);
    memread_d   = (state_d == S_RD) || (state_d == S_RMW_RD);
    memwrite_d  = (state_d == S_WR);
    rsp_valid_d = (state_d == S_RESP);
    rsp_err_d   = accept && req_err;
    rsp_rdata_d = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (accept && !req_err) begin
      mem_addr_d = 32'(bus.req_addr[AW-1:2]);
      if (bus.req_write && (bus.req_size == SZ_WORD)) begin
        mem_wdata_d = bus.req_wdata;
      end
    end
    if (state_q == S_RD) begin
      rsp_rdata_d = load_val;
    end
    if (state_q == S_RMW_RD) begin
      mem_wdata_d = merged;
    end
  end

  // Request fields are held for the whole operation; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q   <= SZ_BYTE;
      lane_q   <= '0;
      wdata_q  <= '0;
      signed_q <= 1'b0;
    end else if (accept) begin
      size_q   <= size_e'(bus.req_size);
      lane_q   <= bus.req_addr[1:0];
      wdata_q  <= bus.req_wdata[15:0];
      signed_q <= bus.req_signed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_write_data_o = mem_wdata_q;
  assign mem_memread_o    = memread_q;
  assign mem_memwrite_o   = memwrite_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a 256-word memory, a per-cycle
// expectation model built from the load/store rules, directed and random traffic.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_if bus();

  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_memwrite;
  logic        mem_memread;

  mem_access_ctrl #(.DEPTH_LOG2(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .mem_addr_o       (mem_addr),
    .mem_write_data_o (mem_write_data),
    .mem_memwrite_o   (mem_memwrite),
    .mem_memread_o    (mem_memread),
    .mem_read_data_i  (mem_read_data)
  );

  function automatic logic [31:0] pat(input int i);
    return (32'h9E37_79B9 * 32'(i + 1)) ^ 32'(i << 5);
  endfunction

  // Data memory: combinational read, write on the rising edge.
  logic [31:0] mem [256];
  logic        mem_init_done = 1'b0;
  assign mem_read_data = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (mem_memwrite) begin
      mem[mem_addr[7:0]] <= mem_write_data;
    end
  end

  // Reference model state and per-cycle expectations.
  logic [31:0] ref_mem [256];

  typedef struct {
    int          tag;
    logic        ready, rd, wr, rsp, err;
    logic [31:0] rdata, addr, wdata;
  } exp_t;

  exp_t slot [8];
  int   cyc = 0;
  logic chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    check("mem_en_exclusive", 32'(mem_memread & mem_memwrite), 32'h0);
    if (chk_en) begin
      e.tag = cyc; e.ready = 1'b1; e.rd = 1'b0; e.wr = 1'b0; e.rsp = 1'b0; e.err = 1'b0;
      e.rdata = '0; e.addr = '0; e.wdata = '0;
      if (slot[cyc % 8].tag == cyc) e = slot[cyc % 8];
      check("req_ready",  32'(bus.req_ready),  32'(e.ready));
      check("mem_memread", 32'(mem_memread),   32'(e.rd));
      check("mem_memwrite", 32'(mem_memwrite), 32'(e.wr));
      check("rsp_valid",  32'(bus.rsp_valid),  32'(e.rsp));
      check("rsp_err",    32'(bus.rsp_err),    32'(e.err));
      check("rsp_rdata",  bus.rsp_rdata,       e.rdata);
      if (e.rd || e.wr) check("mem_addr", mem_addr, e.addr);
      if (e.wr)         check("mem_write_data", mem_write_data, e.wdata);
    end
  end

  task automatic put(input int c, input logic rd, input logic wr, input logic rsp, input logic err,
                     input logic [31:0] rdata, input logic [31:0] addr, input logic [31:0] wdata);
    slot[c % 8].tag   = c;
    slot[c % 8].ready = 1'b0;
    slot[c % 8].rd    = rd;
    slot[c % 8].wr    = wr;
    slot[c % 8].rsp   = rsp;
    slot[c % 8].err   = err;
    slot[c % 8].rdata = rdata;
    slot[c % 8].addr  = addr;
    slot[c % 8].wdata = wdata;
  endtask

  task automatic scramble();
    bus.req_valid  = 1'($urandom);
    bus.req_write  = 1'($urandom);
    bus.req_size   = 2'($urandom);
    bus.req_signed = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  // Called at negedge+1 of an idle cycle; returns at negedge+1 of the next idle cycle.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] got_rdata, output logic got_err);
    logic        bad;
    int          c, lat, sh;
    logic [31:0] wi, word, val, mask;
    c   = cyc;
    bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
       || (a[31:10] != '0);
    wi  = 32'(a[9:2]);
    sh  = (sz == 2'b00) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
    mask = (sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    if (bad) begin
      lat = 1;
      put(c + 1, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0);
    end else if (!w) begin
      word = ref_mem[a[9:2]];
      if (sz == 2'b10) begin
        val = word;
      end else begin
        val = (word >> sh) & mask;
        if (sg && (val & ((mask >> 1) + 32'h1)) != 0) val = val | ~mask;
      end
      lat = 2;
      put(c + 1, 1, 0, 0, 0, 32'h0, wi, 32'h0);
      put(c + 2, 0, 0, 1, 0, val, 32'h0, 32'h0);
    end else if (sz == 2'b10) begin
      lat = 2;
      ref_mem[a[9:2]] = wd;
      put(c + 1, 0, 1, 0, 0, 32'h0, wi, wd);
      put(c + 2, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);
    end else begin
      lat  = 3;
      word = (ref_mem[a[9:2]] & ~(mask << sh)) | ((wd & mask) << sh);
      ref_mem[a[9:2]] = word;
      put(c + 1, 1, 0, 0, 0, 32'h0, wi, 32'h0);
      put(c + 2, 0, 1, 0, 0, 32'h0, wi, word);
      put(c + 3, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);
    end
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    repeat (lat - 1) begin
      #1 scramble();
      @(posedge clk);
    end
    #1 scramble();
    @(negedge clk);
    got_rdata = bus.rsp_rdata;
    got_err   = bus.rsp_err;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic abort_store(input logic in_wr, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] r;
    logic        er;
    chk_en = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    if (in_wr) begin
      @(posedge clk);
      #1 check("abort_wr_active", 32'(mem_memwrite), 32'h1);
    end else begin
      check("abort_rmw_active", 32'(mem_memread), 32'h1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_memwrite_drop", 32'(mem_memwrite), 32'h0);
    check("abort_memread_drop", 32'(mem_memread), 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_rsp_in_reset", 32'(bus.rsp_valid), 32'h0);
    end
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_rsp_after", 32'(bus.rsp_valid), 32'h0);
    end
    #1 chk_en = 1'b1;
    issue(1'b0, 2'b10, 1'b0, {a[31:2], 2'b00}, 32'h0, r, er);
    check("abort_word_unchanged", r, ref_mem[a[9:2]]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        er;
    logic [1:0]  sz;
    logic [31:0] a;

    for (int i = 0; i < 8; i++) slot[i].tag = -1;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);

    // Reset held with a word store already presented.
    rst_n = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_write_data", mem_write_data, 32'h0);
    check("rst_memwrite", 32'(mem_memwrite), 32'h0);
    check("rst_memread", 32'(mem_memread), 32'h0);
    mem_init_done = 1'b1;
    #1 rst_n = 1'b1;
    check("ready_after_release", 32'(bus.req_ready), 32'h1);
    chk_en = 1'b1;

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, r, er);
    check("st_word_rdata_zero", r, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r, er);
    check("ld_word_deadbeef", r, 32'hDEAD_BEEF);

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, r, er);
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA, r, er);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r, er);
    check("rmw_byte_merge", r, 32'h11AA_3344);
    issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, r, er);
    check("ld_byte_signed", r, 32'hFFFF_FFAA);
    issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, r, er);
    check("ld_byte_unsigned", r, 32'h0000_00AA);

    issue(1'b1, 2'b10, 1'b0, 32'h14, 32'h8001_1234, r, er);
    issue(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, r, er);
    check("ld_half_signed", r, 32'hFFFF_8001);
    issue(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, r, er);
    check("ld_half_unsigned", r, 32'h0000_8001);
    issue(1'b1, 2'b01, 1'b0, 32'h14, 32'h1234_5555, r, er);
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, r, er);
    check("rmw_half_merge", r, 32'h8001_5555);

    issue(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, r, er);
    check("err_half_misaligned", 32'(er), 32'h1);
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, r, er);
    check("err_word_misaligned", 32'(er), 32'h1);
    check("err_rdata_zero", r, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, r, er);
    check("err_size_illegal", 32'(er), 32'h1);
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, r, er);
    check("err_out_of_range", 32'(er), 32'h1);
    issue(1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF_FFFF, r, er);
    check("err_store_half", 32'(er), 32'h1);
    issue(1'b1, 2'b10, 1'b0, 32'h410, 32'h0, r, er);
    check("err_store_range", 32'(er), 32'h1);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r, er);
    check("err_no_write_10", r, 32'h11AA_3344);
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, r, er);
    check("err_no_write_14", r, 32'h8001_5555);

    for (int n = 0; n < 300; n++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 127) : $urandom_range(0, 1023);
      if ($urandom_range(0, 7) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(10, 31));
      issue(1'($urandom), sz, 1'($urandom), a, $urandom, r, er);
      repeat ($urandom_range(0, 1)) begin
        @(negedge clk);
        #1;
      end
    end

    abort_store(1'b1, 32'h21, 32'h0000_0077);
    abort_store(1'b0, 32'h26, 32'h0000_0066);

    for (int i = 0; i < 256; i++) check("mem_final", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store initiator sitting in the MEM stage between pipeline and the 256-word data memory. Accepts one byte-addressed load or store per handshake and drives the memory's word-indexed `memread`/`memwrite` port. Sub-word stores are handled by read-modify-write; sub-word loads get lane extraction and sign or zero extension. Each request returns one response pulse, and misaligned or out-of-range requests are rejected without touching memory.

## Interface
- DEPTH_LOG2, 8: log2 of memory depth in words; valid byte addresses are 0 .. 2^(DEPTH_LOG2+2)-1.
- clk  in  1  rising-edge clock (memory samples reads on falling edge).
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; request accepted on the rising edge where valid & ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid: misaligned, illegal size, or out of range.
- mem_addr  out  32  word index = req_addr[DEPTH_LOG2+1:2], zero-extended.
- mem_write_data  out  32  word driven to memory.
- mem_memwrite  out  1  memory write enable.
- mem_memread  out  1  memory read enable.
- mem_read_data  in  32  memory read word; valid by the falling edge of a cycle in which mem_memread=1.

## Operation
- States: IDLE, RD, RMW_RD, WR, RESP. All outputs registered. mem_memread and mem_memwrite are never both 1.
- Error check at acceptance: err if size=11, half with addr[0]=1, word with addr[1:0]≠0, or addr[31:DEPTH_LOG2+2]≠0.
  - IDLE→RESP with rsp_err=1 and rsp_rdata=0.
  - No memory enable is asserted.
- Load: IDLE→RD.
  - RD: mem_memread=1.
  - At the end of RD, capture mem_read_data and extract the lane.
  - RD→RESP.
- Word store: IDLE→WR.
  - WR: mem_memwrite=1 and mem_write_data=req_wdata.
  - WR→RESP.
- Byte/half store: IDLE→RMW_RD.
  - RMW_RD: mem_memread=1.
  - At the end of RMW_RD, merge the store data into the captured word.
  - RMW_RD→WR (merged word)→RESP.
- Lanes, little-endian:
  - Byte k=addr[1:0] occupies bits [8k+7:8k].
  - Half h=addr[1] occupies bits [16h+15:16h].
  - The merge replaces only the addressed lane; the other bits come from the read word.
- Extension: signed copies the lane MSB into the upper bits; unsigned fills the upper bits with 0. Word loads ignore req_signed.
- RESP: rsp_valid=1 for exactly one cycle, then →IDLE. rsp_rdata and rsp_err are cleared to 0 in all non-RESP cycles.
- mem_addr and mem_write_data hold their last value when unused.

## Timing
- Cycle 0 is the cycle in which the request is accepted.
- Load: mem_memread=1 in cycle 1; rsp_valid in cycle 2.
- Word store: mem_memwrite=1 in cycle 1, and the memory writes on the rising edge closing cycle 1; rsp_valid in cycle 2.
- Sub-word store: read in cycle 1, write in cycle 2, rsp_valid in cycle 3.
- Error: rsp_valid in cycle 1.
- req_ready=0 from the cycle after acceptance through the RESP cycle. The next acceptance is possible in the cycle after RESP. Peak throughput: one load per 3 cycles.
- Reset values: state IDLE, req_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_addr=0, mem_write_data=0, mem_memwrite=0, mem_memread=0.
- Reset mid-operation:
  - All enables drop immediately (asynchronously), and no response is issued.
  - If reset is asserted before the rising edge that closes WR, memory is not written.
  - A read-modify-write aborted in RMW_RD leaves memory unchanged.
- req_* inputs are ignored outside IDLE.
- req_* values are latched at acceptance; later changes to the inputs have no effect on the operation in flight.

## Test plan
- Reset with req_valid=1 held: all outputs 0 during reset; first acceptance on the first rising edge after release, with req_ready=1.
- Word store 0xDEADBEEF at byte addr 0x10, then word load at 0x10:
  - Store: mem_addr=4, mem_memwrite pulses in cycle 1, rsp_valid in cycle 2 with rdata 0.
  - Load: rsp_rdata=0xDEADBEEF 2 cycles after acceptance.
- Memory word 4 preloaded 0x11223344; byte store 0xAA at addr 0x12:
  - Read in cycle 1, write 0x11AA3344 in cycle 2, rsp_valid in cycle 3.
  - Signed byte load at 0x12 returns 0xFFFFFFAA.
  - Unsigned byte load at 0x12 returns 0x000000AA.
- Half load 0x8001 lane at addr 0x16, signed → 0xFFFF8001, unsigned → 0x00008001. Half store 0x5555 at 0x14 changes only bits [15:0].
- Half at 0x13, word at 0x12, size=11, addr 0x400:
  - Each gives rsp_err=1 in cycle 1, and mem enables never assert.
  - A follow-up load confirms memory is unchanged.
- Assert rst_n=0 during WR of a byte store: mem_memwrite falls immediately, no rsp_valid, target word unchanged; checker asserts enables never both 1 throughout.
